// File: rtl/uart_pkg.sv
// Shared register offsets, CON bit positions and the FSM state type
// used by both serial directions of the memory-mapped UART.
package uart_pkg;

    localparam logic [7:0] UART_TXD = 8'h18;
    localparam logic [7:0] UART_RXD = 8'h1C;
    localparam logic [7:0] UART_CON = 8'h20;

    localparam int unsigned CON_RX_IRQ_EN = 0;
    localparam int unsigned CON_TX_IRQ_EN = 1;
    localparam int unsigned CON_RX_VALID  = 2;
    localparam int unsigned CON_TX_DONE   = 3;
    localparam int unsigned CON_TX_BUSY   = 4;
    localparam int unsigned CON_OVERRUN   = 5;
    localparam int unsigned CON_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, and one-cycle
// done / frame-error pulses alongside the assembled byte.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_ferr
);

    localparam int unsigned     CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q;
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = ST_START;
            end
            ST_START: begin
                // Re-check at half a bit; a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_byte = shift_q;
    assign rx_done = done_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/uart_per.sv
// Memory-mapped UART peripheral: TXD/RXD/CON registers, 8N1 transmitter,
// receiver instance and a level interrupt built from the CON flags.
module uart_per
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        um_wr,
    input  logic        um_rd,
    output logic [31:0] um_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0] off;
    logic       wr_txd, wr_con, rd_rxd, rd_con;
    logic       unused_bits;

    assign off         = addr[7:0];
    assign wr_txd      = um_wr && (off == UART_TXD);
    assign wr_con      = um_wr && (off == UART_CON);
    assign rd_rxd      = um_rd && (off == UART_RXD);
    assign rd_con      = um_rd && (off == UART_CON);
    assign unused_bits = ^{addr[31:8], wdata[31:8]};

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_fin;
    logic          tx_busy;

    logic       rx_irq_en_q, rx_irq_en_d;
    logic       tx_irq_en_q, tx_irq_en_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_done_q, tx_done_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] rx_data_q, rx_data_d;

    logic [7:0] rx_byte;
    logic       rx_done, rx_ferr;
    logic [6:0] con_val;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .reset  (reset),
        .rx_in  (uart_rx),
        .rx_byte(rx_byte),
        .rx_done(rx_done),
        .rx_ferr(rx_ferr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_irq_en_q <= tx_irq_en_d;
            rx_valid_q  <= rx_valid_d;
            tx_done_q   <= tx_done_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_fin     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (wr_txd) begin
                    tx_state_d = ST_START;
                    tx_shift_d = wdata[7:0];
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                    tx_fin     = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign tx_busy = (tx_state_q != ST_IDLE);

    // Clears are applied first so that a same-cycle set always wins.
    always_comb begin
        rx_irq_en_d = rx_irq_en_q;
        tx_irq_en_d = tx_irq_en_q;
        rx_valid_d  = rx_valid_q;
        tx_done_d   = tx_done_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_data_d   = rx_data_q;
        if (wr_con) begin
            rx_irq_en_d = wdata[CON_RX_IRQ_EN];
            tx_irq_en_d = wdata[CON_TX_IRQ_EN];
        end
        if (rd_rxd) rx_valid_d = 1'b0;
        if (rd_con) begin
            tx_done_d   = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_byte;
            if (rx_valid_q && !rd_rxd) overrun_d = 1'b1;
        end
        if (rx_ferr) frame_err_d = 1'b1;
        if (tx_fin)  tx_done_d   = 1'b1;
    end

    always_comb begin
        con_val                = '0;
        con_val[CON_RX_IRQ_EN] = rx_irq_en_q;
        con_val[CON_TX_IRQ_EN] = tx_irq_en_q;
        con_val[CON_RX_VALID]  = rx_valid_q;
        con_val[CON_TX_DONE]   = tx_done_q;
        con_val[CON_TX_BUSY]   = tx_busy;
        con_val[CON_OVERRUN]   = overrun_q;
        con_val[CON_FRAME_ERR] = frame_err_q;
    end

    always_comb begin
        um_data = '0;
        case (off)
            UART_RXD: um_data = {24'b0, rx_data_q};
            UART_CON: um_data = {25'b0, con_val};
            default:  um_data = '0;
        endcase
    end

    assign uart_tx = tx_q;
    assign irq     = (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & tx_done_q);

endmodule
